// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider producing MIPS-style HI (remainder)
// and LO (quotient) write values. One quotient bit per cycle, WIDTH cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; hi_o/lo_o hold the last result
// S_BUSY | shifting out one quotient bit per cycle, busy asserted
// S_DONE | one-cycle result strobe; a new start may be accepted here
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_en,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             accept;
  logic             div_zero;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  // A new operation is only taken outside BUSY and never alongside cancel.
  assign accept   = (state != S_BUSY) && start && !cancel;
  assign div_zero = (divisor == '0);

  // Both flags decode the state register only, so no input reaches them.
  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; cancel dominates start, divide-by-zero skips BUSY.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = div_zero ? S_DONE : S_BUSY;
        else        state_next = S_IDLE;
      end
      S_BUSY: begin
        if (cancel)               state_next = S_IDLE;
        else if (cnt_q == '0)     state_next = S_DONE;
        else                      state_next = S_BUSY;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand magnitudes and one restoring step, plus the final sign fix-up.
  always_comb begin
    dvd_neg   = signed_en & dividend[WIDTH-1];
    dvs_neg   = signed_en & divisor[WIDTH-1];
    dvd_mag   = dvd_neg ? (~dividend + ONE) : dividend;
    dvs_mag   = dvs_neg ? (~divisor + ONE) : divisor;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    q_bit     = ~diff[WIDTH];
    rem_step  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], q_bit};
    quo_fix   = neg_quo_q ? (~quo_step + ONE) : quo_step;
    rem_fix   = neg_rem_q ? (~rem_step + ONE) : rem_step;
  end

  // Datapath: latch on accept, iterate in BUSY, publish result only on the
  // edge that enters DONE so hi_o/lo_o hold between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else if (accept) begin
      rem_q     <= '0;
      quo_q     <= dvd_mag;
      dvs_q     <= dvs_mag;
      cnt_q     <= CNT_INIT;
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
      if (div_zero) begin
        hi_o <= dividend;
        lo_o <= '1;
      end
    end else if (state == S_BUSY && !cancel) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q - CNT_ONE;
      if (cnt_q == '0) begin
        hi_o <= rem_fix;
        lo_o <= quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: timing, signed/unsigned results, divide by
// zero, cancel, back-to-back and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_en;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_en (signed_en),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  // Called at a negedge in cycle T; start is sampled by the edge ending T.
  // Returns at the negedge of cycle T+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_en = s;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Starting at the negedge of cycle T+1, finds the cycle offset k of done.
  task automatic wait_done(output int lat, output int busy_cnt, output bit both);
    lat = 1; busy_cnt = 0; both = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) busy_cnt++;
      if (busy && done) both = 1'b1;
      if (done) return;
      lat++;
      @(negedge clk);
    end
    lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_en = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hi_o !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
    total++; if (lo_o !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
  endtask

  task automatic test_unsigned();
    int lat, bc; bit both;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(lat, bc, both);
    total++; if (lat !== 33) begin bad++; $display("FAIL u100_7_latency got=%0d exp=33", lat); end
    total++; if (bc !== 32) begin bad++; $display("FAIL u100_7_busy_cycles got=%0d exp=32", bc); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL u100_7_busy_done_overlap got=%b exp=0", both); end
    total++; if (lo_o !== 32'd14) begin bad++; $display("FAIL u100_7_lo got=%h exp=%h", lo_o, 32'd14); end
    total++; if (hi_o !== 32'd2) begin bad++; $display("FAIL u100_7_hi got=%h exp=%h", hi_o, 32'd2); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL u100_7_done_one_cycle got=%b exp=0", done); end
    total++; if (lo_o !== 32'd14) begin bad++; $display("FAIL u100_7_lo_hold got=%h exp=%h", lo_o, 32'd14); end
  endtask

  task automatic test_signed();
    logic [31:0] va [4]; logic [31:0] vb [4]; logic vs [4];
    logic [31:0] eq [4]; logic [31:0] er [4];
    int lat, bc; bit both;
    va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;          vs[0] = 1'b1; eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF;
    va[1] = 32'd7;         vb[1] = 32'hFFFF_FFFE;  vs[1] = 1'b1; eq[1] = 32'hFFFF_FFFD; er[1] = 32'd1;
    va[2] = 32'hFFFF_FFF9; vb[2] = 32'hFFFF_FFFE;  vs[2] = 1'b1; eq[2] = 32'd3;         er[2] = 32'hFFFF_FFFF;
    va[3] = 32'hFFFF_FFF9; vb[3] = 32'd2;          vs[3] = 1'b0; eq[3] = 32'h7FFF_FFFC; er[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vs[i]);
      wait_done(lat, bc, both);
      total++; if (lat !== 33) begin bad++; $display("FAIL signed_case%0d_latency got=%0d exp=33", i, lat); end
      total++; if (lo_o !== eq[i]) begin bad++; $display("FAIL signed_case%0d_lo got=%h exp=%h", i, lo_o, eq[i]); end
      total++; if (hi_o !== er[i]) begin bad++; $display("FAIL signed_case%0d_hi got=%h exp=%h", i, hi_o, er[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    int lat, bc; bit both;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bc, both);
    total++; if (lo_o !== 32'h8000_0000) begin bad++; $display("FAIL ovf_signed_lo got=%h exp=80000000", lo_o); end
    total++; if (hi_o !== 32'd0) begin bad++; $display("FAIL ovf_signed_hi got=%h exp=0", hi_o); end
    @(negedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, bc, both);
    total++; if (lo_o !== 32'd0) begin bad++; $display("FAIL ovf_unsigned_lo got=%h exp=0", lo_o); end
    total++; if (hi_o !== 32'h8000_0000) begin bad++; $display("FAIL ovf_unsigned_hi got=%h exp=80000000", hi_o); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, bc; bit both;
    issue(32'd5, 32'd0, 1'b0);
    wait_done(lat, bc, both);
    total++; if (lat !== 1) begin bad++; $display("FAIL divzero_latency got=%0d exp=1", lat); end
    total++; if (bc !== 0) begin bad++; $display("FAIL divzero_busy_cycles got=%0d exp=0", bc); end
    total++; if (lo_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divzero_lo got=%h exp=ffffffff", lo_o); end
    total++; if (hi_o !== 32'd5) begin bad++; $display("FAIL divzero_hi got=%h exp=5", hi_o); end
    @(negedge clk);
    total++; if ((busy | done) !== 1'b0) begin bad++; $display("FAIL divzero_idle_after got=%b%b exp=00", busy, done); end
  endtask

  // Entered with hi_o=5, lo_o=ffffffff left by the divide-by-zero test.
  task automatic test_cancel();
    int lat, bc; bit both; bit saw_done;
    issue(32'd100, 32'd7, 1'b0);              // now at T+1
    saw_done = 1'b0;
    for (int i = 0; i < 9; i++) begin         // advance to T+10
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    cancel = 1'b1;
    @(negedge clk);                           // T+11
    cancel = 1'b0;
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL cancel_early_done got=1 exp=0"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cancel_done got=%b exp=0", done); end
    total++; if (hi_o !== 32'd5) begin bad++; $display("FAIL cancel_hi_hold got=%h exp=5", hi_o); end
    total++; if (lo_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cancel_lo_hold got=%h exp=ffffffff", lo_o); end
    issue(32'd100, 32'd7, 1'b0);              // start at T+11
    wait_done(lat, bc, both);
    total++; if (lat !== 33) begin bad++; $display("FAIL cancel_restart_latency got=%0d exp=33", lat); end
    total++; if (lo_o !== 32'd14) begin bad++; $display("FAIL cancel_restart_lo got=%h exp=e", lo_o); end
    total++; if (hi_o !== 32'd2) begin bad++; $display("FAIL cancel_restart_hi got=%h exp=2", hi_o); end
    @(negedge clk);
    // cancel wins over start in the same cycle
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd0; signed_en = 1'b0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    total++; if ((busy | done) !== 1'b0) begin bad++; $display("FAIL cancel_vs_start got=%b%b exp=00", busy, done); end
    total++; if (hi_o !== 32'd2) begin bad++; $display("FAIL cancel_vs_start_hi got=%h exp=2", hi_o); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit both; bit saw_done;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(lat, bc, both);                 // now in the DONE cycle
    total++; if (lo_o !== 32'd14) begin bad++; $display("FAIL b2b_first_lo got=%h exp=e", lo_o); end
    total++; if (hi_o !== 32'd2) begin bad++; $display("FAIL b2b_first_hi got=%h exp=2", hi_o); end
    issue(32'd50, 32'd6, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy got=%b exp=1", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_second_done got=%b exp=0", done); end
    repeat (4) @(negedge clk);
    issue(32'd9, 32'd0, 1'b1);                // must be ignored while busy
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL b2b_start_in_busy_done got=1 exp=0"); end
    wait_done(lat, bc, both);
    total++; if (lat < 1) begin bad++; $display("FAIL b2b_second_timeout got=%0d exp=positive", lat); end
    total++; if (lo_o !== 32'd8) begin bad++; $display("FAIL b2b_second_lo got=%h exp=8", lo_o); end
    total++; if (hi_o !== 32'd2) begin bad++; $display("FAIL b2b_second_hi got=%h exp=2", hi_o); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    issue(32'd100, 32'd7, 1'b0);              // T+1
    repeat (3) @(negedge clk);                // T+4
    rst = 1'b1;                               // sampled by edge ending T+4... held through T+5
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    total++; if (hi_o !== 32'd0) begin bad++; $display("FAIL rst_mid_hi got=%h exp=0", hi_o); end
    total++; if (lo_o !== 32'd0) begin bad++; $display("FAIL rst_mid_lo got=%h exp=0", lo_o); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done | busy) saw_done = 1'b1;
      @(negedge clk);
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rst_mid_activity got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_cancel();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
